// File: rtl/cp0_pkg.sv
// CP0 register layouts plus the TLB operation, state and entry types
// shared by the TLB unit and its matcher.
package cp0_pkg;

  localparam int unsigned TLB_INDEX = 5;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [4:0]  zero;
    logic [7:0]  asid;
  } cp0_entryhi_t;

  typedef struct packed {
    logic [5:0]  fill;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } cp0_entrylo_t;

  typedef struct packed {
    logic                    p;
    logic [30-TLB_INDEX:0]   zero;
    logic [TLB_INDEX-1:0]    index;
  } cp0_index_t;

  typedef struct packed {
    logic [31-TLB_INDEX:0]   zero;
    logic [TLB_INDEX-1:0]    random;
  } cp0_random_t;

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_t;

  typedef enum logic [1:0] {
    TLB_IDLE,
    TLB_PROBE,
    TLB_RESP
  } tlb_state_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_lo_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_lo_t     lo0;
    tlb_lo_t     lo1;
  } tlb_entry_t;

  function automatic logic [TLB_INDEX-1:0] tlb_prio_enc(input logic [2**TLB_INDEX-1:0] m);
    logic [TLB_INDEX-1:0] idx;
    logic                 found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 2**TLB_INDEX; i++) begin
      if (m[i] && !found) begin
        idx   = i[TLB_INDEX-1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic cp0_entrylo_t tlb_lo_pack(input tlb_lo_t lo, input logic g);
    cp0_entrylo_t r;
    r     = '0;
    r.pfn = lo.pfn;
    r.c   = lo.c;
    r.d   = lo.d;
    r.v   = lo.v;
    r.g   = g;
    return r;
  endfunction

  function automatic tlb_lo_t tlb_lo_unpack(input cp0_entrylo_t lo);
    tlb_lo_t r;
    r.pfn = lo.pfn;
    r.c   = lo.c;
    r.d   = lo.d;
    r.v   = lo.v;
    return r;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// 32-way VPN2/ASID comparator with a lowest-index priority encoder.
module tlb_match
  import cp0_pkg::*;
(
  input  logic [2**TLB_INDEX-1:0][18:0] vpn2_i,
  input  logic [2**TLB_INDEX-1:0][7:0]  asid_i,
  input  logic [2**TLB_INDEX-1:0]       g_i,
  input  logic [18:0]                   q_vpn2_i,
  input  logic [7:0]                    q_asid_i,
  output logic [2**TLB_INDEX-1:0]       match_o,
  input  logic [2**TLB_INDEX-1:0]       enc_i,
  output logic                          hit_o,
  output logic [TLB_INDEX-1:0]          idx_o
);

  always_comb begin
    match_o = '0;
    for (int unsigned k = 0; k < 2**TLB_INDEX; k++) begin
      match_o[k] = (vpn2_i[k] == q_vpn2_i) && (g_i[k] || (asid_i[k] == q_asid_i));
    end
  end

  // Encoder input is separate so the probe path can encode registered match bits.
  assign hit_o = |enc_i;
  assign idx_o = tlb_prio_enc(enc_i);

endmodule

// File: rtl/tlb_unit.sv
// 32-entry MIPS-style TLB: CP0 TLBP/TLBR/TLBWI/TLBWR request handling plus
// combinational instruction and data lookup ports.
module tlb_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  output logic        req_ready,
  input  logic [31:0] entryhi_in,
  input  logic [31:0] entrylo0_in,
  input  logic [31:0] entrylo1_in,
  input  logic [31:0] index_in,
  input  logic [31:0] random_in,
  output logic        resp_valid,
  output logic [1:0]  resp_op,
  output logic [31:0] entryhi_out,
  output logic [31:0] entrylo0_out,
  output logic [31:0] entrylo1_out,
  output logic [31:0] index_out,
  output logic [31:0] pagemask_out,
  input  logic [31:0] i_vaddr,
  input  logic [31:0] d_vaddr,
  output logic        i_hit,
  output logic        d_hit,
  output logic [31:0] i_lo,
  output logic [31:0] d_lo
);

  cp0_entryhi_t hi_in;
  cp0_entrylo_t lo0_in, lo1_in;
  cp0_index_t   idx_in;
  cp0_random_t  rnd_in;
  tlb_op_t      op_in;

  assign hi_in  = cp0_entryhi_t'(entryhi_in);
  assign lo0_in = cp0_entrylo_t'(entrylo0_in);
  assign lo1_in = cp0_entrylo_t'(entrylo1_in);
  assign idx_in = cp0_index_t'(index_in);
  assign rnd_in = cp0_random_t'(random_in);
  assign op_in  = tlb_op_t'(req_op);

  tlb_state_t   state_q, state_d;
  tlb_op_t      op_q;
  tlb_entry_t   tlb_q [2**TLB_INDEX];
  logic [2**TLB_INDEX-1:0] probe_q;
  cp0_entryhi_t hi_out_q;
  cp0_entrylo_t lo0_out_q, lo1_out_q;
  cp0_index_t   index_out_q;
  logic         accept;

  logic [2**TLB_INDEX-1:0][18:0] tab_vpn2;
  logic [2**TLB_INDEX-1:0][7:0]  tab_asid;
  logic [2**TLB_INDEX-1:0]       tab_g;

  for (genvar k = 0; k < 2**TLB_INDEX; k++) begin : g_tab
    assign tab_vpn2[k] = tlb_q[k].vpn2;
    assign tab_asid[k] = tlb_q[k].asid;
    assign tab_g[k]    = tlb_q[k].g;
  end

  logic [2**TLB_INDEX-1:0] probe_match, i_match, d_match;
  logic                    probe_hit;
  logic [TLB_INDEX-1:0]    probe_idx, i_idx, d_idx;

  tlb_match u_probe_match (
    .vpn2_i(tab_vpn2), .asid_i(tab_asid), .g_i(tab_g),
    .q_vpn2_i(hi_in.vpn2), .q_asid_i(hi_in.asid),
    .match_o(probe_match), .enc_i(probe_q),
    .hit_o(probe_hit), .idx_o(probe_idx)
  );

  tlb_match u_i_match (
    .vpn2_i(tab_vpn2), .asid_i(tab_asid), .g_i(tab_g),
    .q_vpn2_i(i_vaddr[31:13]), .q_asid_i(hi_in.asid),
    .match_o(i_match), .enc_i(i_match),
    .hit_o(i_hit), .idx_o(i_idx)
  );

  tlb_match u_d_match (
    .vpn2_i(tab_vpn2), .asid_i(tab_asid), .g_i(tab_g),
    .q_vpn2_i(d_vaddr[31:13]), .q_asid_i(hi_in.asid),
    .match_o(d_match), .enc_i(d_match),
    .hit_o(d_hit), .idx_o(d_idx)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      TLB_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (op_in == TLBP) ? TLB_PROBE : TLB_RESP;
        end
      end
      TLB_PROBE: state_d = TLB_RESP;
      TLB_RESP:  state_d = TLB_IDLE;
      default:   state_d = TLB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= TLB_IDLE;
    else       state_q <= state_d;
  end

  tlb_entry_t           wr_entry, rd_entry;
  logic [TLB_INDEX-1:0] wr_idx;

  always_comb begin
    wr_entry.vpn2 = hi_in.vpn2;
    wr_entry.asid = hi_in.asid;
    wr_entry.g    = lo0_in.g & lo1_in.g;
    wr_entry.lo0  = tlb_lo_unpack(lo0_in);
    wr_entry.lo1  = tlb_lo_unpack(lo1_in);
    wr_idx        = (op_in == TLBWR) ? rnd_in.random : idx_in.index;
    rd_entry      = tlb_q[idx_in.index];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < 2**TLB_INDEX; k++) tlb_q[k] <= '0;
      probe_q     <= '0;
      op_q        <= TLBP;
      hi_out_q    <= '0;
      lo0_out_q   <= '0;
      lo1_out_q   <= '0;
      index_out_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op_in;
        case (op_in)
          TLBP: probe_q <= probe_match;
          TLBR: begin
            hi_out_q  <= '{vpn2: rd_entry.vpn2, zero: '0, asid: rd_entry.asid};
            lo0_out_q <= tlb_lo_pack(rd_entry.lo0, rd_entry.g);
            lo1_out_q <= tlb_lo_pack(rd_entry.lo1, rd_entry.g);
          end
          default: tlb_q[wr_idx] <= wr_entry;
        endcase
      end
      if (state_q == TLB_PROBE) begin
        index_out_q <= '{p: ~probe_hit, zero: '0, index: probe_idx};
      end
    end
  end

  always_comb begin
    i_lo = '0;
    d_lo = '0;
    if (i_hit) i_lo = tlb_lo_pack(i_vaddr[12] ? tlb_q[i_idx].lo1 : tlb_q[i_idx].lo0, tlb_q[i_idx].g);
    if (d_hit) d_lo = tlb_lo_pack(d_vaddr[12] ? tlb_q[d_idx].lo1 : tlb_q[d_idx].lo0, tlb_q[d_idx].g);
  end

  assign resp_valid   = (state_q == TLB_RESP);
  assign resp_op      = op_q;
  assign entryhi_out  = hi_out_q;
  assign entrylo0_out = lo0_out_q;
  assign entrylo1_out = lo1_out_q;
  assign index_out    = index_out_q;
  assign pagemask_out = '0;

  logic unused_bits;
  assign unused_bits = ^{hi_in.zero, lo0_in.fill, lo1_in.fill, idx_in.p, idx_in.zero,
                         rnd_in.zero, i_vaddr[11:0], d_vaddr[11:0]};

endmodule

// File: tb/tb_tlb_unit.sv
// Bench for tlb_unit: a transaction-level TLB model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic        req_ready;
  logic [31:0] entryhi_in = '0, entrylo0_in = '0, entrylo1_in = '0;
  logic [31:0] index_in = '0, random_in = '0;
  logic        resp_valid;
  logic [1:0]  resp_op;
  logic [31:0] entryhi_out, entrylo0_out, entrylo1_out, index_out, pagemask_out;
  logic [31:0] i_vaddr = '0, d_vaddr = '0;
  logic        i_hit, d_hit;
  logic [31:0] i_lo, d_lo;

  tlb_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
    .index_in(index_in), .random_in(random_in),
    .resp_valid(resp_valid), .resp_op(resp_op),
    .entryhi_out(entryhi_out), .entrylo0_out(entrylo0_out), .entrylo1_out(entrylo1_out),
    .index_out(index_out), .pagemask_out(pagemask_out),
    .i_vaddr(i_vaddr), .d_vaddr(d_vaddr), .i_hit(i_hit), .d_hit(d_hit), .i_lo(i_lo), .d_lo(d_lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: table of entries, pending response bookkeeping, expected output registers.
  logic [31:0] m_vpn2 [32];
  logic [31:0] m_asid [32];
  logic [31:0] m_lo0  [32];
  logic [31:0] m_lo1  [32];
  logic [31:0] m_g    [32];
  bit          m_resp, m_probe, started;
  logic [31:0] e_hi, e_lo0, e_lo1, e_idx, pend_idx, e_op;

  function automatic int find(input logic [31:0] vpn2, input logic [31:0] asid);
    for (int i = 0; i < 32; i++)
      if (m_vpn2[i] == vpn2 && (m_g[i] != 0 || m_asid[i] == asid)) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int sel, w, r;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_vpn2[i] = 0; m_asid[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0; m_g[i] = 0;
      end
      m_resp = 0; m_probe = 0; started = 1;
      e_hi = 0; e_lo0 = 0; e_lo1 = 0; e_idx = 0; e_op = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_probe) begin
      m_probe = 0; m_resp = 1; e_idx = pend_idx;
    end else if (req_valid) begin
      e_op = {30'd0, req_op};
      sel  = int'(index_in % 32);
      case (req_op)
        2'd0: begin
          r = find(entryhi_in >> 13, entryhi_in % 256);
          pend_idx = (r < 0) ? 32'h8000_0000 : r;
          m_probe = 1;
        end
        2'd1: begin
          e_hi  = (m_vpn2[sel] << 13) | m_asid[sel];
          e_lo0 = m_lo0[sel] | m_g[sel];
          e_lo1 = m_lo1[sel] | m_g[sel];
          m_resp = 1;
        end
        default: begin
          w = (req_op == 2'd3) ? int'(random_in % 32) : sel;
          m_vpn2[w] = entryhi_in >> 13;
          m_asid[w] = entryhi_in % 256;
          m_lo0[w]  = entrylo0_in & 32'h03FF_FFFE;
          m_lo1[w]  = entrylo1_in & 32'h03FF_FFFE;
          m_g[w]    = entrylo0_in & entrylo1_in & 32'h1;
          m_resp = 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin : compare
    int r;
    logic [31:0] exp_lo;
    if (started) begin
      chk("req_ready", req_ready, !m_resp && !m_probe);
      chk("resp_valid", resp_valid, m_resp);
      if (m_resp) chk("resp_op", resp_op, e_op);
      chk("entryhi_out", entryhi_out, e_hi);
      chk("entrylo0_out", entrylo0_out, e_lo0);
      chk("entrylo1_out", entrylo1_out, e_lo1);
      chk("index_out", index_out, e_idx);
      chk("pagemask_out", pagemask_out, 0);
      r = find(i_vaddr >> 13, entryhi_in % 256);
      exp_lo = 0;
      if (r >= 0) exp_lo = (i_vaddr[12] ? m_lo1[r] : m_lo0[r]) | m_g[r];
      chk("i_hit", i_hit, r >= 0);
      chk("i_lo", i_lo, exp_lo);
      r = find(d_vaddr >> 13, entryhi_in % 256);
      exp_lo = 0;
      if (r >= 0) exp_lo = (d_vaddr[12] ? m_lo1[r] : m_lo0[r]) | m_g[r];
      chk("d_hit", d_hit, r >= 0);
      chk("d_lo", d_lo, exp_lo);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] hi, l0, l1, idx, rnd,
                       output int unsigned lat);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    chk("accept_wait", req_ready, 1);
    req_valid = 1'b1; req_op = op; entryhi_in = hi; entrylo0_in = l0; entrylo1_in = l1;
    index_in = idx; random_in = rnd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_index_out", index_out, 0);

    issue(2'd1, 32'h0, 32'h0, 32'h0, 32'd7, 32'h0, lat);
    chk("tlbr7_latency", lat, 1);
    chk("tlbr7_hi", entryhi_out, 32'h0);
    chk("tlbr7_lo0", entrylo0_out, 32'h0);

    issue(2'd2, 32'h0040_2005, 32'h0000_1006, 32'h0000_1047, 32'd3, 32'h0, lat);
    chk("tlbwi_latency", lat, 1);
    issue(2'd1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFE3, 32'h0, lat);
    chk("tlbr3_hi", entryhi_out, 32'h0040_2005);
    chk("tlbr3_lo0", entrylo0_out, 32'h0000_1006);
    chk("tlbr3_lo1", entrylo1_out, 32'h0000_1046);
    chk("tlbr3_pagemask", pagemask_out, 32'h0);

    issue(2'd0, 32'h0040_2005, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    chk("tlbp_latency", lat, 2);
    chk("tlbp_hit3", index_out, 32'h0000_0003);
    issue(2'd0, 32'h0040_2006, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    chk("tlbp_miss", index_out, 32'h8000_0000);

    issue(2'd2, 32'h0040_2011, 32'h0000_2007, 32'h0000_208F, 32'd5, 32'h0, lat);
    issue(2'd2, 32'h0040_2011, 32'h0000_2007, 32'h0000_208F, 32'd9, 32'h0, lat);
    @(negedge clk);
    entryhi_in = 32'h0040_2022; d_vaddr = 32'h0040_3000; i_vaddr = 32'h0040_2000;
    @(negedge clk);
    chk("global_d_hit", d_hit, 1);
    chk("global_d_lo", d_lo, 32'h0000_208F);
    chk("global_i_lo", i_lo, 32'h0000_2007);
    issue(2'd0, 32'h0040_20AB, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    chk("tlbp_dup_lowest", index_out, 32'h0000_0005);

    @(negedge clk);
    entryhi_in = 32'h7FFF_E0CC; entrylo0_in = 32'h0000_0002; entrylo1_in = 32'h0000_0006;
    random_in = 32'hFFFF_FFFF; i_vaddr = 32'h7FFF_E000;
    req_op = 2'd3; req_valid = 1'b1;
    #1 chk("wr_same_cycle_ihit", i_hit, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_next_cycle_ihit", i_hit, 1);
    chk("wr_next_cycle_ilo", i_lo, 32'h0000_0002);

    issue(2'd0, 32'h0040_2005, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; entryhi_in = 32'h0040_2011;
    @(negedge clk);
    req_valid = 1'b0;
    chk("probe_state_ready", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_probe_no_resp", resp_valid, 0);
    chk("rst_probe_ready", req_ready, 1);
    issue(2'd1, 32'h0, 32'h0, 32'h0, 32'd5, 32'h0, lat);
    chk("rst_cleared_hi5", entryhi_out, 32'h0);

    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; index_in = 32'd2;
    entryhi_in = 32'h1234_5077; entrylo0_in = 32'h0000_3003; entrylo1_in = 32'h0000_3043;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    issue(2'd1, 32'h0, 32'h0, 32'h0, 32'd2, 32'h0, lat);
    chk("rst_write_suppressed_hi", entryhi_out, 32'h0);
    chk("rst_write_suppressed_lo0", entrylo0_out, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
